// File: rtl/pow2_pkg.sv
// pow2_pkg: shared definitions for the bit-serial power-of-two checker.
//   state_e      FSM encoding (IDLE, SCAN, DONE)
//   ONES_SAT     saturation value of the ones counter
//   pow2_clog2   ceil(log2(v)) helper used to size the exponent
package pow2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] ONES_SAT = 2'd2;

    // Constant-evaluable ceil(log2(v)); v >= 2 in all legal uses.
    function automatic int unsigned pow2_clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pow2_shift_scanner.sv
// pow2_shift_scanner: LSB-first datapath for the power-of-two checker.
// Holds the shift register, bit index, saturating ones counter and the
// index of the first set bit.
//   clk, reset        clock, synchronous active-high reset
//   i_load, i_data    load a new word (clears index, ones, exponent)
//   i_en              examine bit 0 and advance one position
//   o_last_bit_c      the bit being examined this cycle is bit W-1
//   o_second_one_c    this cycle's bit is the second set bit seen
//   o_ones_nxt_c      ones count including this cycle's bit
//   o_exp_nxt_c       first-set-bit index including this cycle's bit
module pow2_shift_scanner
    import pow2_pkg::*;
#(
    parameter int unsigned W  = 8,
    parameter int unsigned EW = pow2_clog2(W)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_load,
    input  logic          i_en,
    input  logic [W-1:0]  i_data,
    output logic          o_last_bit_c,
    output logic          o_second_one_c,
    output logic [1:0]    o_ones_nxt_c,
    output logic [EW-1:0] o_exp_nxt_c
);

    logic [W-1:0]  r_shift;
    logic [EW-1:0] r_idx;
    logic [1:0]    r_ones;
    logic [EW-1:0] r_exp;
    logic          w_bit;

    assign w_bit = r_shift[0];

    // Look-ahead values so the FSM can decide on the same edge the bit is consumed.
    always_comb begin
        o_last_bit_c   = i_en && (r_idx == EW'(W - 1));
        o_second_one_c = i_en && w_bit && (r_ones == (ONES_SAT - 2'd1));
        o_ones_nxt_c   = r_ones;
        o_exp_nxt_c    = r_exp;
        if (w_bit && (r_ones != ONES_SAT)) begin
            o_ones_nxt_c = r_ones + 2'd1;
        end
        if (w_bit && (r_ones == 2'd0)) begin
            o_exp_nxt_c = r_idx;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift <= '0;
            r_idx   <= '0;
            r_ones  <= '0;
            r_exp   <= '0;
        end else if (i_load) begin
            r_shift <= i_data;
            r_idx   <= '0;
            r_ones  <= '0;
            r_exp   <= '0;
        end else if (i_en) begin
            r_shift <= r_shift >> 1;
            r_idx   <= r_idx + EW'(1);
            r_ones  <= o_ones_nxt_c;
            r_exp   <= o_exp_nxt_c;
        end
    end

endmodule

// File: rtl/pow2_seq_checker.sv
// pow2_seq_checker: accepts a W-bit word over valid/ready, scans it one bit
// per clock LSB first, and reports whether it is a power of two and its
// exponent over a second valid/ready handshake.
// Build option: define POW2_EARLY_EXIT_EN to finish the scan as soon as a
// second set bit is seen (results unchanged, latency shorter).
//   clk, reset              clock, synchronous active-high reset
//   in_valid/in_ready       input handshake (in_ready high only in IDLE)
//   in_data                 word to check, bit 0 is the LSB
//   out_valid/out_ready     result handshake
//   is_pow2, exponent       result; exponent is 0 unless is_pow2
module pow2_seq_checker
    import pow2_pkg::*;
#(
    parameter int unsigned W         = 8,
    parameter bit          ALLOW_ONE = 1'b0,
    localparam int unsigned EW       = pow2_clog2(W)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          is_pow2,
    output logic [EW-1:0] exponent
);

    state_e        r_state;
    state_e        w_state_nxt;
    logic          r_out_valid;
    logic          r_is_pow2;
    logic [EW-1:0] r_exponent;
    logic          w_out_valid_nxt;
    logic          w_is_pow2_nxt;
    logic [EW-1:0] w_exponent_nxt;

    logic          w_load;
    logic          w_en;
    logic          w_last_bit;
    logic          w_second_one;
    logic [1:0]    w_ones_nxt;
    logic [EW-1:0] w_scan_exp;
    logic          w_exit;
    logic          w_pow2;

    pow2_shift_scanner #(
        .W  (W),
        .EW (EW)
    ) u_scanner (
        .clk            (clk),
        .reset          (reset),
        .i_load         (w_load),
        .i_en           (w_en),
        .i_data         (in_data),
        .o_last_bit_c   (w_last_bit),
        .o_second_one_c (w_second_one),
        .o_ones_nxt_c   (w_ones_nxt),
        .o_exp_nxt_c    (w_scan_exp)
    );

`ifdef POW2_EARLY_EXIT_EN
    // A second set bit already rules the word out; stop scanning.
    assign w_exit = w_last_bit || w_second_one;
`else
    logic w_unused_second_one;
    assign w_unused_second_one = w_second_one;
    assign w_exit              = w_last_bit;
`endif

    // Exactly one set bit, and bit 0 alone only counts when ALLOW_ONE is set.
    assign w_pow2 = (w_ones_nxt == 2'd1) && (ALLOW_ONE || (w_scan_exp != '0));

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt     = r_state;
        w_load          = 1'b0;
        w_en            = 1'b0;
        in_ready        = 1'b0;
        w_out_valid_nxt = r_out_valid;
        w_is_pow2_nxt   = r_is_pow2;
        w_exponent_nxt  = r_exponent;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = SCAN;
                end
            end
            SCAN: begin
                w_en = 1'b1;
                if (w_exit) begin
                    w_state_nxt     = DONE;
                    w_out_valid_nxt = 1'b1;
                    w_is_pow2_nxt   = w_pow2;
                    w_exponent_nxt  = w_pow2 ? w_scan_exp : '0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt     = IDLE;
                    w_out_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_is_pow2   <= 1'b0;
            r_exponent  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_is_pow2   <= w_is_pow2_nxt;
            r_exponent  <= w_exponent_nxt;
        end
    end

    assign out_valid = r_out_valid;
    assign is_pow2   = r_is_pow2;
    assign exponent  = r_exponent;

endmodule

// File: tb/tb_pow2_seq_checker.sv
// tb_pow2_seq_checker: directed bench for pow2_seq_checker.
// Three instances: W=8/ALLOW_ONE=0 (index 0), W=8/ALLOW_ONE=1 (index 1),
// W=16/ALLOW_ONE=0 (index 2). Expected latencies cover both builds of
// POW2_EARLY_EXIT_EN.
module tb_pow2_seq_checker;

`ifdef POW2_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  iv;
    logic [2:0]  ordy;
    wire  [2:0]  ir;
    wire  [2:0]  ov;
    wire  [2:0]  ip;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic [15:0] d16;
    wire  [2:0]  e0;
    wire  [2:0]  e1;
    wire  [3:0]  e16;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pow2_seq_checker #(.W(8), .ALLOW_ONE(1'b0)) u_dut0 (
        .clk(clk), .reset(reset),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_data(d0),
        .out_valid(ov[0]), .out_ready(ordy[0]),
        .is_pow2(ip[0]), .exponent(e0)
    );

    pow2_seq_checker #(.W(8), .ALLOW_ONE(1'b1)) u_dut1 (
        .clk(clk), .reset(reset),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_data(d1),
        .out_valid(ov[1]), .out_ready(ordy[1]),
        .is_pow2(ip[1]), .exponent(e1)
    );

    pow2_seq_checker #(.W(16), .ALLOW_ONE(1'b0)) u_dut16 (
        .clk(clk), .reset(reset),
        .in_valid(iv[2]), .in_ready(ir[2]), .in_data(d16),
        .out_valid(ov[2]), .out_ready(ordy[2]),
        .is_pow2(ip[2]), .exponent(e16)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] ex_of(input int d);
        case (d)
            0:       return {1'b0, e0};
            1:       return {1'b0, e1};
            default: return e16;
        endcase
    endfunction

    task automatic set_data(input int d, input logic [15:0] v);
        case (d)
            0:       d0  = v[7:0];
            1:       d1  = v[7:0];
            default: d16 = v;
        endcase
    endtask

    // Push one word, time the result, check it, optionally stall, then release.
    task automatic run_word(input string tag, input int d, input logic [15:0] data,
                            input int lat_full, input int lat_early,
                            input bit exp_p, input int exp_e, input int hold);
        int lat;
        int n;
        bit ir_bad;
        lat = EE ? lat_early : lat_full;
        check({tag, ".in_ready_idle"}, 64'(ir[d]), 64'd1);
        iv[d]   = 1'b1;
        set_data(d, data);
        ordy[d] = (hold == 0);
        tick();
        iv[d] = 1'b0;
        set_data(d, ~data);
        n      = 0;
        ir_bad = 1'b0;
        while (!ov[d] && n < 100) begin
            if (ir[d]) ir_bad = 1'b1;
            tick();
            n++;
        end
        if (ir[d]) ir_bad = 1'b1;
        check({tag, ".latency"}, 64'(n), 64'(lat));
        check({tag, ".in_ready_busy"}, 64'(ir_bad), 64'd0);
        check({tag, ".is_pow2"}, 64'(ip[d]), 64'(exp_p));
        check({tag, ".exponent"}, 64'(ex_of(d)), 64'(exp_e));
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, ".hold"}, {59'd0, ov[d], ip[d], ex_of(d)},
                  {59'd0, 1'b1, exp_p, 4'(exp_e)});
        end
        ordy[d] = 1'b1;
        tick();
        check({tag, ".release"}, {62'd0, ov[d], ir[d]}, 64'b01);
        ordy[d] = 1'b0;
    endtask

    initial begin
        iv    = '0;
        ordy  = '0;
        d0    = '0;
        d1    = '0;
        d16   = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        check("rst.in_ready", 64'(ir), 64'h7);
        check("rst.out_valid", 64'(ov), 64'h0);
        check("rst.is_pow2", 64'(ip), 64'h0);
        check("rst.exponent", 64'(ex_of(0)), 64'h0);

        // W=8, ALLOW_ONE=0
        run_word("w8_80", 0, 16'h0080, 8, 8, 1'b1, 7, 0);
        run_word("w8_01", 0, 16'h0001, 8, 8, 1'b0, 0, 0);
        run_word("w8_5A", 0, 16'h005A, 8, 4, 1'b0, 0, 0);
        run_word("w8_00", 0, 16'h0000, 8, 8, 1'b0, 0, 0);
        run_word("w8_FF", 0, 16'h00FF, 8, 2, 1'b0, 0, 0);
        run_word("w8_03", 0, 16'h0003, 8, 2, 1'b0, 0, 0);
        run_word("w8_20bp", 0, 16'h0020, 8, 8, 1'b1, 5, 5);

        // W=8, ALLOW_ONE=1
        run_word("a1_01", 1, 16'h0001, 8, 8, 1'b1, 0, 0);
        run_word("a1_80", 1, 16'h0080, 8, 8, 1'b1, 7, 0);
        run_word("a1_0C", 1, 16'h000C, 8, 4, 1'b0, 0, 0);

        // W=16
        run_word("w16_8000", 2, 16'h8000, 16, 16, 1'b1, 15, 0);
        run_word("w16_0001", 2, 16'h0001, 16, 16, 1'b0, 0, 0);
        run_word("w16_0101", 2, 16'h0101, 16, 9, 1'b0, 0, 0);
        run_word("w16_0400", 2, 16'h0400, 16, 16, 1'b1, 10, 0);

        // Reset in the middle of a scan discards the word.
        ordy[0] = 1'b1;
        iv[0]   = 1'b1;
        d0      = 8'h10;
        tick();
        iv[0] = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst.in_ready", 64'(ir[0]), 64'd1);
        check("mid_rst.out_valid", 64'(ov[0]), 64'd0);
        check("mid_rst.result", {60'd0, ip[0], e0}, 64'd0);
        for (int i = 0; i < 10; i++) tick();
        check("mid_rst.discarded", 64'(ov[0]), 64'd0);
        ordy[0] = 1'b0;
        run_word("post_rst_04", 0, 16'h0004, 8, 8, 1'b1, 2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pow2_seq_checker.md
Name: pow2_seq_checker

Overview:
- Parametrised, sequential successor to the combinational 8-bit power-of-two detector.
- Accepts a W-bit word through a valid/ready handshake and scans it bit-serially, one bit per clock, LSB first.
- Reports whether the word is a power of two and, if so, its exponent, through a valid/ready output handshake.
- Sits between a producer FSM and a consumer that needs the log2 of single-bit masks.

Parameters:
- W, 8, data width in bits; legal range 2..64.
- ALLOW_ONE, 0, when 0 the value 1 (2^0) is not a power of two, matching the existing detector; when 1 the value 1 is a power of two with exponent 0.
- EW, $clog2(W), exponent width; derived, not overridden.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  producer has a word on in_data.
- in_ready  out  1  checker can accept a word.
- in_data  in  W  word to check; bit 0 is the LSB.
- out_valid  out  1  result is available.
- out_ready  in  1  consumer accepts the result.
- is_pow2  out  1  1 when the word is a power of two.
- exponent  out  EW  index of the set bit when is_pow2=1, otherwise 0.

Behaviour:
- Reset: while reset=1 at a clock edge, the next state is IDLE and these registers clear: out_valid=0, is_pow2=0, exponent=0, scan counter=0, ones count=0, shift register=0. Reset takes effect from any state, including mid-scan; the word being scanned is discarded and never reported.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1 (decoded combinationally from the state).
  - Accept occurs when in_valid=1 at the clock edge: latch in_data into the shift register, clear the ones count, clear the scan index, move to SCAN.
- SCAN:
  - in_ready=0.
  - Each cycle, examine shift register bit 0.
  - If the bit is 1 and the ones count is 0, record the exponent as the current index.
  - The ones count increments and saturates at 2, so it is a 2-bit register.
  - Shift the register right by one and increment the index.
  - After the bit with index W-1 has been examined, move to DONE.
- Entering DONE: out_valid goes to 1 on the same edge.
  - is_pow2 = (ones==1) && (ALLOW_ONE || exponent!=0).
  - exponent output = the recorded index if is_pow2=1, otherwise 0.
- DONE:
  - Outputs are held stable while out_ready=0.
  - When out_ready=1 at the edge: out_valid falls to 0 and the FSM returns to IDLE.
  - No bypass from DONE straight to a new accept; the next accept happens in IDLE one cycle later at the earliest.
- Latency: with the accept at edge t, out_valid=1 after edge t+W. Throughput is one word per W+2 cycles.
- Boundary values:
  - Zero word: is_pow2=0, exponent=0.
  - Word with bit W-1 set alone: is_pow2=1, exponent=W-1.
  - All ones: is_pow2=0.
- Handshake rule: in_data and in_valid are ignored outside IDLE. The producer must hold in_data only for the accept cycle.

Optional Feature:
- Macro: POW2_EARLY_EXIT_EN.
- Defined: in SCAN, when the ones count reaches 2, the FSM moves to DONE on that same edge (is_pow2=0, exponent=0). Latency becomes k+1 edges after the accept, where k is the index of the second set bit. Results are identical to the non-early-exit build; only timing differs.
- Undefined: every scan takes exactly W cycles.

Decomposition:
- Shared package pow2_pkg:
  - state encoding constants IDLE=2'd0, SCAN=2'd1, DONE=2'd2;
  - the ones-count saturation constant (2);
  - a clog2 helper function.
- One natural sub-module: pow2_shift_scanner.
  - Contents: shift register, index counter, saturating ones counter, exponent capture.
  - Controls: load and enable inputs.
  - Outputs: last_bit and second_one.
  - Top-level owns the FSM and the handshakes.

Test Plan:
- W=8, ALLOW_ONE=0, accept 8'h80, out_ready=1 -> out_valid rises 8 edges after the accept, is_pow2=1, exponent=3'd7.
- W=8: 8'h01 with ALLOW_ONE=0 -> is_pow2=0, exponent=0. Same word with ALLOW_ONE=1 -> is_pow2=1, exponent=0.
- W=8: 8'h5A, 8'h00 and 8'hFF back-to-back -> each gives is_pow2=0, exponent=0. in_ready=0 throughout SCAN and DONE.
- Backpressure: accept 8'h20, hold out_ready=0 for 5 cycles -> out_valid=1, is_pow2=1, exponent=5 stable throughout; released one cycle after out_ready=1.
- Reset mid-operation: accept 8'h10, assert reset on scan cycle 3 -> next cycle in IDLE, in_ready=1, out_valid=0. A following accept of 8'h04 -> exponent=2.
- POW2_EARLY_EXIT_EN defined, accept 8'h03 -> out_valid after 2 edges, is_pow2=0. W=16 with 16'h8000 -> exponent=4'd15 after 16 edges.
